// File: rtl/imm_gen_pipe_if.sv
// rtl/imm_gen_pipe_if.sv - instruction-in / immediate-out handshake bundle for imm_gen_pipe
interface imm_gen_pipe_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_inst;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic            out_illegal;

    modport slave (
        input  in_valid, in_inst, out_ready,
        output in_ready, out_valid, out_inst, out_imm, out_fmt, out_illegal
    );

    modport master (
        output in_valid, in_inst, out_ready,
        input  in_ready, out_valid, out_inst, out_imm, out_fmt, out_illegal
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - pipelined RV32I/RV64I immediate generator with optional skid buffer
module imm_gen_pipe #(
    parameter int XLEN = 32,
    parameter bit SKID = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    imm_gen_pipe_if.slave bus
);
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;

    localparam logic [2:0] FMT_NONE  = 3'd0;
    localparam logic [2:0] FMT_I     = 3'd1;
    localparam logic [2:0] FMT_S     = 3'd2;
    localparam logic [2:0] FMT_B     = 3'd3;
    localparam logic [2:0] FMT_U     = 3'd4;
    localparam logic [2:0] FMT_J     = 3'd5;
    localparam logic [2:0] FMT_SHAMT = 3'd6;

    logic [31:0]     src_inst;
    logic [31:0]     imm32;
    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_fmt;
    logic            dec_illegal;
    logic            is_shift;
    logic            shift_funct_ok;

    logic            in_ready_c;
    logic            in_fire;
    logic            out_valid_r;
    logic [31:0]     out_inst_r;
    logic [XLEN-1:0] out_imm_r;
    logic [2:0]      out_fmt_r;
    logic            out_illegal_r;

    // Shift immediates are zero-extended small values, so the final sign extension
    // from imm32[31] is harmless for them and exact for every other format.
    always_comb begin
        imm32          = '0;
        dec_fmt        = FMT_NONE;
        dec_illegal    = 1'b0;
        is_shift       = (src_inst[14:12] == 3'b001) || (src_inst[14:12] == 3'b101);
        shift_funct_ok = (src_inst[14:12] == 3'b001) ? (src_inst[31:26] == 6'b000000)
                       : ((src_inst[31:26] == 6'b000000) || (src_inst[31:26] == 6'b010000));
        case (src_inst[6:0])
            OPC_LUI, OPC_AUIPC: begin
                dec_fmt = FMT_U;
                imm32   = {src_inst[31:12], 12'b0};
            end
            OPC_JAL: begin
                dec_fmt = FMT_J;
                imm32   = {{11{src_inst[31]}}, src_inst[31], src_inst[19:12], src_inst[20],
                           src_inst[30:21], 1'b0};
            end
            OPC_JALR: begin
                dec_fmt     = FMT_I;
                imm32       = {{20{src_inst[31]}}, src_inst[31:20]};
                dec_illegal = (src_inst[14:12] != 3'b000);
            end
            OPC_BRANCH: begin
                dec_fmt = FMT_B;
                imm32   = {{19{src_inst[31]}}, src_inst[31], src_inst[7], src_inst[30:25],
                           src_inst[11:8], 1'b0};
            end
            OPC_LOAD: begin
                dec_fmt = FMT_I;
                imm32   = {{20{src_inst[31]}}, src_inst[31:20]};
            end
            OPC_STORE: begin
                dec_fmt = FMT_S;
                imm32   = {{20{src_inst[31]}}, src_inst[31:25], src_inst[11:7]};
            end
            OPC_OP_IMM: begin
                if (is_shift) begin
                    dec_fmt     = FMT_SHAMT;
                    imm32       = (XLEN == 64) ? {26'b0, src_inst[25:20]} : {27'b0, src_inst[24:20]};
                    dec_illegal = !shift_funct_ok || ((XLEN == 32) && src_inst[25]);
                end else begin
                    dec_fmt = FMT_I;
                    imm32   = {{20{src_inst[31]}}, src_inst[31:20]};
                end
            end
            OPC_OP_IMM32: begin
                if (XLEN == 64) begin
                    if (is_shift) begin
                        dec_fmt     = FMT_SHAMT;
                        imm32       = {27'b0, src_inst[24:20]};
                        dec_illegal = !shift_funct_ok || src_inst[25];
                    end else begin
                        dec_fmt = FMT_I;
                        imm32   = {{20{src_inst[31]}}, src_inst[31:20]};
                    end
                end
            end
            default: begin
                imm32 = '0;
            end
        endcase
        dec_imm = XLEN'($signed(imm32));
    end

    assign in_fire = bus.in_valid && in_ready_c;

    generate
        if (SKID) begin : g_skid
            logic        skid_valid;
            logic [31:0] skid_inst;

            // The skid holds the raw word; it is decoded when it moves to the output reg.
            assign src_inst   = skid_valid ? skid_inst : bus.in_inst;
            assign in_ready_c = !skid_valid;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    skid_valid    <= 1'b0;
                    skid_inst     <= '0;
                    out_valid_r   <= 1'b0;
                    out_inst_r    <= '0;
                    out_imm_r     <= '0;
                    out_fmt_r     <= FMT_NONE;
                    out_illegal_r <= 1'b0;
                end else if (!out_valid_r || bus.out_ready) begin
                    if (skid_valid || in_fire) begin
                        skid_valid    <= 1'b0;
                        out_valid_r   <= 1'b1;
                        out_inst_r    <= src_inst;
                        out_imm_r     <= dec_imm;
                        out_fmt_r     <= dec_fmt;
                        out_illegal_r <= dec_illegal;
                    end else begin
                        out_valid_r <= 1'b0;
                    end
                end else if (in_fire) begin
                    skid_valid <= 1'b1;
                    skid_inst  <= bus.in_inst;
                end
            end
        end else begin : g_noskid
            assign src_inst   = bus.in_inst;
            assign in_ready_c = !out_valid_r || bus.out_ready;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    out_valid_r   <= 1'b0;
                    out_inst_r    <= '0;
                    out_imm_r     <= '0;
                    out_fmt_r     <= FMT_NONE;
                    out_illegal_r <= 1'b0;
                end else if (in_fire) begin
                    out_valid_r   <= 1'b1;
                    out_inst_r    <= src_inst;
                    out_imm_r     <= dec_imm;
                    out_fmt_r     <= dec_fmt;
                    out_illegal_r <= dec_illegal;
                end else if (bus.out_ready) begin
                    out_valid_r <= 1'b0;
                end
            end
        end
    endgenerate

    assign bus.in_ready    = in_ready_c;
    assign bus.out_valid   = out_valid_r;
    assign bus.out_inst    = out_inst_r;
    assign bus.out_imm     = out_imm_r;
    assign bus.out_fmt     = out_fmt_r;
    assign bus.out_illegal = out_illegal_r;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - directed-vector bench for imm_gen_pipe (XLEN=32/SKID=1 and XLEN=64/SKID=0)
module tb_imm_gen_pipe;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    imm_gen_pipe_if #(.XLEN(32)) bus32 ();
    imm_gen_pipe_if #(.XLEN(64)) bus64 ();

    imm_gen_pipe #(.XLEN(32), .SKID(1'b1)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
    imm_gen_pipe #(.XLEN(64), .SKID(1'b0)) dut64 (.clk(clk), .rst_n(rst_n), .bus(bus64));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] imm32;
        logic [2:0]  fmt32;
        logic        ill32;
        logic [63:0] imm64;
        logic [2:0]  fmt64;
        logic        ill64;
    } vec_t;

    vec_t tbl[14];

    initial begin
        tbl[0]  = '{32'h004000EF, 32'h00000004, 3'd5, 1'b0, 64'h0000000000000004, 3'd5, 1'b0};
        tbl[1]  = '{32'hFFDFF06F, 32'hFFFFFFFC, 3'd5, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd5, 1'b0};
        tbl[2]  = '{32'hFE000CE3, 32'hFFFFFFF8, 3'd3, 1'b0, 64'hFFFFFFFFFFFFFFF8, 3'd3, 1'b0};
        tbl[3]  = '{32'h4030D093, 32'h00000003, 3'd6, 1'b0, 64'h0000000000000003, 3'd6, 1'b0};
        tbl[4]  = '{32'h02009093, 32'h00000000, 3'd6, 1'b1, 64'h0000000000000020, 3'd6, 1'b0};
        tbl[5]  = '{32'h800000B7, 32'h80000000, 3'd4, 1'b0, 64'hFFFFFFFF80000000, 3'd4, 1'b0};
        tbl[6]  = '{32'hFE20AE23, 32'hFFFFFFFC, 3'd2, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0};
        tbl[7]  = '{32'h01012283, 32'h00000010, 3'd1, 1'b0, 64'h0000000000000010, 3'd1, 1'b0};
        tbl[8]  = '{32'hFFF09067, 32'hFFFFFFFF, 3'd1, 1'b1, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b1};
        tbl[9]  = '{32'hFFFFFF8B, 32'h00000000, 3'd0, 1'b0, 64'h0000000000000000, 3'd0, 1'b0};
        tbl[10] = '{32'h80109093, 32'h00000001, 3'd6, 1'b1, 64'h0000000000000001, 3'd6, 1'b1};
        tbl[11] = '{32'h0030909B, 32'h00000000, 3'd0, 1'b0, 64'h0000000000000003, 3'd6, 1'b0};
        tbl[12] = '{32'h12345017, 32'h12345000, 3'd4, 1'b0, 64'h0000000012345000, 3'd4, 1'b0};
        tbl[13] = '{32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0};
    end

    task automatic idle_all();
        bus32.in_valid  = 1'b0;
        bus32.in_inst   = '0;
        bus32.out_ready = 1'b1;
        bus64.in_valid  = 1'b0;
        bus64.in_inst   = '0;
        bus64.out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_all();
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({bus32.out_valid, bus32.in_ready, bus32.out_inst, bus32.out_imm, bus32.out_fmt, bus32.out_illegal}
            !== {1'b0, 1'b1, 32'h0, 32'h0, 3'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset32: valid=%0b ready=%0b inst=%h imm=%h fmt=%0d ill=%0b, expected 0 1 0 0 0 0",
                     bus32.out_valid, bus32.in_ready, bus32.out_inst, bus32.out_imm, bus32.out_fmt, bus32.out_illegal);
        end
        vectors++;
        if ({bus64.out_valid, bus64.in_ready, bus64.out_inst, bus64.out_imm, bus64.out_fmt, bus64.out_illegal}
            !== {1'b0, 1'b1, 32'h0, 64'h0, 3'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset64: valid=%0b ready=%0b inst=%h imm=%h fmt=%0d ill=%0b, expected 0 1 0 0 0 0",
                     bus64.out_valid, bus64.in_ready, bus64.out_inst, bus64.out_imm, bus64.out_fmt, bus64.out_illegal);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_jal();
        bus32.in_valid = 1'b1;
        bus32.in_inst  = 32'h004000EF;
        bus64.in_valid = 1'b1;
        bus64.in_inst  = 32'h004000EF;
        @(posedge clk);
        #1;
        idle_all();
        vectors++;
        if ({bus32.out_valid, bus32.out_imm, bus32.out_fmt} !== {1'b1, 32'd4, 3'd5}) begin
            miscompares++;
            $display("FAIL jal32: valid=%0b imm=%h fmt=%0d, expected 1 00000004 5",
                     bus32.out_valid, bus32.out_imm, bus32.out_fmt);
        end
        vectors++;
        if ({bus64.out_valid, bus64.out_imm, bus64.out_fmt} !== {1'b1, 64'd4, 3'd5}) begin
            miscompares++;
            $display("FAIL jal64: valid=%0b imm=%h fmt=%0d, expected 1 0000000000000004 5",
                     bus64.out_valid, bus64.out_imm, bus64.out_fmt);
        end
        @(posedge clk);
        #1;
        vectors++;
        if ({bus32.out_valid, bus64.out_valid} !== 2'b00) begin
            miscompares++;
            $display("FAIL jal_drain: valid32=%0b valid64=%0b, expected 0 0", bus32.out_valid, bus64.out_valid);
        end
    endtask

    // Whole table streamed with no gaps: each result must appear the cycle after its word.
    task automatic test_decode_stream();
        for (int i = 0; i < 14; i++) begin
            bus32.in_valid = 1'b1;
            bus32.in_inst  = tbl[i].inst;
            bus64.in_valid = 1'b1;
            bus64.in_inst  = tbl[i].inst;
            @(posedge clk);
            #1;
            vectors++;
            if ({bus32.out_valid, bus32.out_inst, bus32.out_imm, bus32.out_fmt, bus32.out_illegal}
                !== {1'b1, tbl[i].inst, tbl[i].imm32, tbl[i].fmt32, tbl[i].ill32}) begin
                miscompares++;
                $display("FAIL decode32[%0d] inst=%h: got v=%0b i=%h imm=%h fmt=%0d ill=%0b, expected v=1 imm=%h fmt=%0d ill=%0b",
                         i, tbl[i].inst, bus32.out_valid, bus32.out_inst, bus32.out_imm, bus32.out_fmt,
                         bus32.out_illegal, tbl[i].imm32, tbl[i].fmt32, tbl[i].ill32);
            end
            vectors++;
            if ({bus64.out_valid, bus64.out_inst, bus64.out_imm, bus64.out_fmt, bus64.out_illegal}
                !== {1'b1, tbl[i].inst, tbl[i].imm64, tbl[i].fmt64, tbl[i].ill64}) begin
                miscompares++;
                $display("FAIL decode64[%0d] inst=%h: got v=%0b i=%h imm=%h fmt=%0d ill=%0b, expected v=1 imm=%h fmt=%0d ill=%0b",
                         i, tbl[i].inst, bus64.out_valid, bus64.out_inst, bus64.out_imm, bus64.out_fmt,
                         bus64.out_illegal, tbl[i].imm64, tbl[i].fmt64, tbl[i].ill64);
            end
        end
        idle_all();
        @(posedge clk);
        #1;
    endtask

    task automatic test_noskid_backpressure();
        bus64.out_ready = 1'b0;
        bus64.in_valid  = 1'b1;
        bus64.in_inst   = 32'h004000EF;
        @(posedge clk);
        #1;
        bus64.in_inst = 32'hFFF00093;
        vectors++;
        if ({bus64.out_valid, bus64.out_inst, bus64.in_ready} !== {1'b1, 32'h004000EF, 1'b0}) begin
            miscompares++;
            $display("FAIL noskid_hold: valid=%0b inst=%h in_ready=%0b, expected 1 004000ef 0",
                     bus64.out_valid, bus64.out_inst, bus64.in_ready);
        end
        @(posedge clk);
        #1;
        vectors++;
        if ({bus64.out_valid, bus64.out_inst, bus64.out_imm} !== {1'b1, 32'h004000EF, 64'd4}) begin
            miscompares++;
            $display("FAIL noskid_stable: valid=%0b inst=%h imm=%h, expected 1 004000ef 4",
                     bus64.out_valid, bus64.out_inst, bus64.out_imm);
        end
        bus64.out_ready = 1'b1;
        #1;
        vectors++;
        if (bus64.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL noskid_ready_comb: in_ready=%0b, expected 1", bus64.in_ready);
        end
        @(posedge clk);
        #1;
        bus64.in_valid = 1'b0;
        vectors++;
        if ({bus64.out_valid, bus64.out_inst, bus64.out_imm, bus64.out_fmt}
            !== {1'b1, 32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 3'd1}) begin
            miscompares++;
            $display("FAIL noskid_next: valid=%0b inst=%h imm=%h fmt=%0d, expected 1 fff00093 ffffffffffffffff 1",
                     bus64.out_valid, bus64.out_inst, bus64.out_imm, bus64.out_fmt);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (bus64.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL noskid_drain: valid=%0b, expected 0", bus64.out_valid);
        end
    endtask

    task automatic test_skid_stream();
        logic [31:0] words [5];
        logic [31:0] imms  [5];
        int idx;
        int rcv;
        int skid_accepts;
        bit saw_drop;
        bit in_fire;
        words = '{32'h004000EF, 32'hFE000CE3, 32'hFFF00093, 32'h800000B7, 32'hFE20AE23};
        imms  = '{32'h00000004, 32'hFFFFFFF8, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFC};
        idx = 0;
        rcv = 0;
        skid_accepts = 0;
        saw_drop = 1'b0;
        for (int cyc = 0; cyc < 40 && rcv < 5; cyc++) begin
            bus32.in_valid  = (idx < 5);
            bus32.in_inst   = (idx < 5) ? words[idx] : 32'h0;
            bus32.out_ready = !(cyc >= 2 && cyc <= 4);
            @(negedge clk);
            in_fire = bus32.in_valid && bus32.in_ready;
            if (!bus32.in_ready) saw_drop = 1'b1;
            if (bus32.out_valid && !bus32.out_ready) begin
                if (in_fire) skid_accepts++;
                vectors++;
                if (bus32.out_inst !== words[rcv]) begin
                    miscompares++;
                    $display("FAIL skid_stall_stable[%0d]: inst=%h, expected %h", rcv, bus32.out_inst, words[rcv]);
                end
            end
            if (bus32.out_valid && bus32.out_ready) begin
                vectors++;
                if ({bus32.out_inst, bus32.out_imm} !== {words[rcv], imms[rcv]}) begin
                    miscompares++;
                    $display("FAIL skid_order[%0d]: inst=%h imm=%h, expected %h %h",
                             rcv, bus32.out_inst, bus32.out_imm, words[rcv], imms[rcv]);
                end
                rcv++;
            end
            @(posedge clk);
            #1;
            if (in_fire) idx++;
        end
        idle_all();
        vectors++;
        if (rcv != 5 || idx != 5) begin
            miscompares++;
            $display("FAIL skid_count: sent=%0d received=%0d, expected 5 5", idx, rcv);
        end
        vectors++;
        if (skid_accepts != 1 || !saw_drop) begin
            miscompares++;
            $display("FAIL skid_fill: accepted_while_stalled=%0d in_ready_dropped=%0b, expected 1 1",
                     skid_accepts, saw_drop);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midflight();
        bus32.out_ready = 1'b0;
        bus32.in_valid  = 1'b1;
        bus32.in_inst   = 32'h004000EF;
        @(posedge clk);
        #1;
        bus32.in_inst = 32'hFE000CE3;
        @(posedge clk);
        #1;
        bus32.in_valid = 1'b0;
        vectors++;
        if ({bus32.out_valid, bus32.in_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL midreset_setup: valid=%0b in_ready=%0b, expected 1 0", bus32.out_valid, bus32.in_ready);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        vectors++;
        if ({bus32.out_valid, bus32.in_ready, bus32.out_inst, bus32.out_imm, bus32.out_fmt, bus32.out_illegal}
            !== {1'b0, 1'b1, 32'h0, 32'h0, 3'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL midreset: valid=%0b ready=%0b inst=%h imm=%h fmt=%0d ill=%0b, expected 0 1 0 0 0 0",
                     bus32.out_valid, bus32.in_ready, bus32.out_inst, bus32.out_imm, bus32.out_fmt, bus32.out_illegal);
        end
        bus32.out_ready = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (bus32.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_stale: valid=%0b inst=%h, expected 0", bus32.out_valid, bus32.out_inst);
        end
        bus32.in_valid = 1'b1;
        bus32.in_inst  = 32'h12345017;
        @(posedge clk);
        #1;
        bus32.in_valid = 1'b0;
        vectors++;
        if ({bus32.out_valid, bus32.out_inst, bus32.out_imm, bus32.out_fmt} !== {1'b1, 32'h12345017, 32'h12345000, 3'd4}) begin
            miscompares++;
            $display("FAIL midreset_after: valid=%0b inst=%h imm=%h fmt=%0d, expected 1 12345017 12345000 4",
                     bus32.out_valid, bus32.out_inst, bus32.out_imm, bus32.out_fmt);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        idle_all();
        test_reset();
        test_jal();
        test_decode_stream();
        test_noskid_backpressure();
        test_skid_stream();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
